// File: rtl/arith_result_buffer.sv
// rtl/arith_result_buffer.sv - capture FIFO for the registered adder/multiplier results
// Credit-based op_ready, one-cycle in-flight tracking, drop counting.
module arith_result_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [4:0]    sum_in,
  input  logic [7:0]    prod_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [12:0]   out_data,
  output logic [CW-1:0] count,
  output logic [7:0]    drop_cnt,
  output logic          drop_flag
);

  localparam int AW = CW - 1;

  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pending;
  logic          push;
  logic          pop;
  logic          accept;
  logic          drop;

  // The in-flight result holds a slot, so credit is counted against stored plus pending.
  assign op_ready  = (count + CW'(pending)) < CW'(DEPTH);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  assign accept = op_valid && op_ready;
  assign drop   = op_valid && !op_ready;
  assign push   = pending;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pending   <= 1'b0;
      drop_cnt  <= '0;
      drop_flag <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      pending <= accept;
      if (push) begin
        mem[wr_ptr] <= {prod_in, sum_in};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (drop) begin
        drop_flag <= 1'b1;
        if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arith_result_buffer.sv
// tb/tb_arith_result_buffer.sv - directed bench for arith_result_buffer
// Models the upstream registered adder/multiplier feeding sum_in/prod_in.
module tb_arith_result_buffer;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [4:0]  sum_in;
  logic [7:0]  prod_in;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_data;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;
  logic        drop_flag;

  logic [3:0]  aa, ab, ma, mb;
  int          vectors;
  int          miscompares;
  logic [12:0] q[$];
  logic [12:0] exp_list[4];

  arith_result_buffer #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .sum_in(sum_in), .prod_in(prod_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .count(count),
    .drop_cnt(drop_cnt), .drop_flag(drop_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_in  <= '0;
      prod_in <= '0;
    end else begin
      sum_in  <= {1'b0, aa} + {1'b0, ab};
      prod_in <= {4'b0, ma} * {4'b0, mb};
    end
  end

  function automatic logic [12:0] ent(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c, input logic [3:0] d);
    logic [7:0] p;
    logic [4:0] s;
    p = {4'b0, c} * {4'b0, d};
    s = {1'b0, a} + {1'b0, b};
    return {p, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    op_valid = v;
    aa = a; ab = b; ma = c; mb = d;
  endtask

  always @(negedge clk) begin
    if (!rst) chk("count_bound", 32'(count <= 3'd4), 32'd1);
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    out_ready = 1'b0;
    set_op(1'b1, 4'd1, 4'd1, 4'd1, 4'd1);
    tick();
    tick();
    rst = 1'b0;
    set_op(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_drop_flag", 32'(drop_flag), 32'd0);

    // single op, latency N+2
    out_ready = 1'b1;
    set_op(1'b1, 4'd3, 4'd5, 4'd7, 4'd9);
    tick();
    op_valid = 1'b0;
    chk("single_n1_valid", 32'(out_valid), 32'd0);
    tick();
    chk("single_n2_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'h07E8);
    tick();
    chk("single_popped", 32'(out_valid), 32'd0);

    // max operands, and hold under back-pressure
    out_ready = 1'b0;
    set_op(1'b1, 4'd15, 4'd15, 4'd15, 4'd15);
    tick();
    op_valid = 1'b0;
    tick();
    chk("max_valid", 32'(out_valid), 32'd1);
    chk("max_data", 32'(out_data), 32'h1C3E);
    tick();
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_data", 32'(out_data), 32'h1C3E);
    out_ready = 1'b1;
    tick();
    chk("max_popped", 32'(out_valid), 32'd0);

    // fill: 6 back-to-back ops, 4 accepted, 2 dropped
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      set_op(1'b1, 4'(i), 4'd0, 4'(i), 4'd1);
      chk($sformatf("fill_op_ready_%0d", i), 32'(op_ready), (i <= 4) ? 32'd1 : 32'd0);
      tick();
    end
    op_valid = 1'b0;
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("fill_drop_flag", 32'(drop_flag), 32'd1);
    chk("fill_op_ready", 32'(op_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("drain_data_%0d", i), 32'(out_data),
          32'(ent(4'(i), 4'd0, 4'(i), 4'd1)));
      tick();
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // full with simultaneous pop and op: op still dropped
    out_ready = 1'b0;
    for (int i = 7; i <= 10; i++) begin
      set_op(1'b1, 4'(i), 4'd1, 4'(i), 4'd2);
      tick();
    end
    op_valid = 1'b0;
    tick();
    chk("full2_count", 32'(count), 32'd4);
    set_op(1'b1, 4'd11, 4'd1, 4'd11, 4'd2);
    out_ready = 1'b1;
    chk("full2_op_ready", 32'(op_ready), 32'd0);
    tick();
    chk("full2_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("full2_count_after_pop", 32'(count), 32'd3);
    out_ready = 1'b0;
    set_op(1'b1, 4'd12, 4'd1, 4'd12, 4'd2);
    chk("full2_reopen", 32'(op_ready), 32'd1);
    tick();
    op_valid = 1'b0;
    tick();
    chk("full2_refill", 32'(count), 32'd4);
    exp_list[0] = ent(4'd8, 4'd1, 4'd8, 4'd2);
    exp_list[1] = ent(4'd9, 4'd1, 4'd9, 4'd2);
    exp_list[2] = ent(4'd10, 4'd1, 4'd10, 4'd2);
    exp_list[3] = ent(4'd12, 4'd1, 4'd12, 4'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full2_data_%0d", i), 32'(out_data), 32'(exp_list[i]));
      tick();
    end
    chk("full2_empty", 32'(out_valid), 32'd0);

    // streaming 20 ops with constant out_ready
    out_ready = 1'b1;
    for (int c = 0; c < 60 && (c < 20 || q.size() != 0); c++) begin
      if (out_valid) begin
        if (q.size() != 0) chk("stream_data", 32'(out_data), 32'(q.pop_front()));
        else chk("stream_spurious", 32'(out_valid), 32'd0);
      end
      chk("stream_count_le2", 32'(count <= 3'd2), 32'd1);
      if (c < 20) begin
        set_op(1'b1, 4'(c), 4'(c * 3), 4'(c + 2), 4'(c * 5 + 1));
        chk("stream_op_ready", 32'(op_ready), 32'd1);
        q.push_back(ent(4'(c), 4'(c * 3), 4'(c + 2), 4'(c * 5 + 1)));
      end else begin
        op_valid = 1'b0;
      end
      tick();
    end
    chk("stream_drained", 32'(q.size()), 32'd0);
    chk("stream_no_drops", 32'(drop_cnt), 32'd3);

    // reset with 3 stored and one in flight
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_op(1'b1, 4'(i), 4'd2, 4'(i), 4'd3);
      tick();
    end
    op_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_op_ready", 32'(op_ready), 32'd1);
    chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("midrst_drop_flag", 32'(drop_flag), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    tick();
    chk("midrst_no_late_push", 32'(count), 32'd0);

    // drop counter saturation: 4 accepted, 256 dropped
    set_op(1'b1, 4'd1, 4'd1, 4'd1, 4'd1);
    for (int i = 0; i < 260; i++) tick();
    op_valid = 1'b0;
    chk("sat_drop_cnt", 32'(drop_cnt), 32'd255);
    chk("sat_count", 32'(count), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arith_result_buffer.md
Name: arith_result_buffer

Overview:
- Downstream capture stage for the registered adder/multiplier pair (5-bit sum, 8-bit product).
- Tracks the one-cycle result latency of that pair and packs each result into a 13-bit entry {product, sum}.
- Buffers entries in a small FIFO and presents them on a valid/ready stream to the next consumer.
- Gives the operand source a credit-based ready so no issued result is ever lost; counts attempts made while not ready.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, 3, count width; equals log2(DEPTH)+1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- op_valid  input  1  operands presented to the adder/multiplier this cycle.
- op_ready  output  1  buffer can accept the result of an operand presented this cycle.
- sum_in  input  5  registered adder result.
- prod_in  input  8  registered multiplier result.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  13  head entry {prod[7:0], sum[4:0]}.
- count  output  CW  entries stored; excludes in-flight.
- drop_cnt  output  8  op_valid cycles seen with op_ready=0; saturates at 255.
- drop_flag  output  1  sticky; set on first drop.

Behaviour:
- Reset (rst=1 at clk edge): FIFO empty, pointers 0, count=0, pending=0, drop_cnt=0, drop_flag=0.
- Outputs after reset: out_valid=0, out_data=0, op_ready=1.
- op_valid during rst is ignored and is not counted as a drop.
- Accept condition: op_valid && op_ready; sets pending=1 at the next edge. Otherwise pending=0.
- pending is a single bit: at most one operand per cycle, each result arrives exactly one cycle later.
- Push: when pending=1, {prod_in, sum_in} is written at the FIFO tail at that edge.
- Latency: operands accepted in cycle N give out_valid=1 in cycle N+2 earliest (FIFO previously empty).
- op_ready = (count + pending) < DEPTH.
  - Derived from registered state only; no combinational path from out_ready.
  - When full, a pop and an op_valid in the same cycle still see op_ready=0 and the op is a drop.
- Drop: op_valid && !op_ready.
  - drop_cnt increments by 1, holding at 255.
  - drop_flag is set to 1 and stays set until rst.
  - Nothing is written for a dropped op.
- Pop: out_valid && out_ready; head pointer advances at the edge.
- out_data is the head entry while out_valid=1. It shows 0 only after reset until the first push.
- out_data and out_valid must not change while out_valid=1 && out_ready=0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push into an empty FIFO with pop also asserted: pop has no effect (out_valid=0), count becomes 1.
- Pointers wrap modulo DEPTH. Overflow is impossible by construction; an assertion in the bench checks count <= DEPTH.
- No underflow: pop only when out_valid=1.
- count range 0..DEPTH. out_valid = (count != 0).
- Reset mid-operation discards stored entries and any pending result. The source must reissue.

Test Plan:
- Single op: aa=3, ab=5, ma=7, mb=9, op_valid 1 cycle, out_ready=1 → out_valid in cycle N+2 for one cycle. out_data=13'h07E8 (prod 63, sum 8).
- Max operands: all 15 → out_data=13'h1C3E (prod 225, sum 30). Checks no truncation.
- Fill with out_ready=0 and 6 back-to-back op_valid:
  - ops 1-4 accepted; op_ready=0 from cycle 4.
  - ops 5-6 dropped: drop_cnt=2, drop_flag=1, count=4.
  - Then out_ready=1 → 4 entries drain in issue order.
- Full plus simultaneous pop and op_valid → op counted as drop. Next cycle op_ready=1 and a new op is accepted.
- Streaming 20 ops with out_ready=1 every cycle → zero drops. count never exceeds 2. Order preserved across pointer wrap.
- With 3 entries stored and pending=1, assert rst for 1 cycle → next cycle count=0, out_valid=0, op_ready=1, drop_cnt=0. The result that was in flight is not pushed.
